// File: rtl/hex_operand_parser.sv
// hex_operand_parser
//   Front end of the hex calculator datapath. Parses ASCII expressions of the
//   form "<hex A>+<hex B>=" (or CR as terminator) arriving from the UART
//   receiver into two DATA_W-bit operands plus carry-in, then offers them to
//   the adder with a valid/ready handshake.
//   Optional feature macro: SUBTRACT_EN -- accept '-' as the operator and
//   present ~B with carry-in 1 so the adder produces A - B.
module hex_operand_parser #(
  parameter int DATA_W     = 32,
  parameter int MAX_DIGITS = DATA_W / 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_cin,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              err
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OUT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sub_q, sub_d;
  logic              err_q, err_d;

  // Byte classification of the incoming character.
  logic       is_num;
  logic       is_upper;
  logic       is_lower;
  logic       is_digit;
  logic [3:0] nibble;
  logic       is_space;
  logic       is_plus;
  logic       is_minus;
  logic       is_term;

  // Decode the received byte into its hex value and operator classes.
  always_comb begin
    is_num   = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_upper = (rx_data >= 8'h41) && (rx_data <= 8'h46);
    is_lower = (rx_data >= 8'h61) && (rx_data <= 8'h66);
    is_digit = is_num || is_upper || is_lower;
    // Letters 'A'/'a' have low nibble 1, so adding 9 maps them onto 10..15.
    nibble   = is_num ? rx_data[3:0] : (rx_data[3:0] + 4'd9);
    is_space = (rx_data == CH_SPACE);
    is_plus  = (rx_data == CH_PLUS);
    is_minus = (rx_data == CH_MINUS);
    is_term  = (rx_data == CH_EQ) || (rx_data == CH_CR);
  end

  // Next-state logic: parse one byte per strobe, hold operands in S_OUT.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    err_d   = 1'b0;

    case (state_q)
      S_A: begin
        if (rx_valid) begin
          if (is_space) begin
            // whitespace between tokens is ignored
          end else if (is_digit) begin
            if (cnt_q == CNT_MAX) begin
              err_d = 1'b1;
            end else begin
              a_d   = {a_q[DATA_W-5:0], nibble};
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (is_plus) begin
            if (cnt_q != '0) begin
              state_d = S_B;
              cnt_d   = '0;
              sub_d   = 1'b0;
            end else begin
              err_d = 1'b1;
            end
`ifdef SUBTRACT_EN
          end else if (is_minus) begin
            if (cnt_q != '0) begin
              state_d = S_B;
              cnt_d   = '0;
              sub_d   = 1'b1;
            end else begin
              err_d = 1'b1;
            end
`endif
          end else begin
            // terminator before any operator, or an unknown byte
            err_d = 1'b1;
          end
        end
      end

      S_B: begin
        if (rx_valid) begin
          if (is_space) begin
            // whitespace between tokens is ignored
          end else if (is_digit) begin
            if (cnt_q == CNT_MAX) begin
              err_d = 1'b1;
            end else begin
              b_d   = {b_q[DATA_W-5:0], nibble};
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (is_term) begin
            if (cnt_q != '0) begin
              state_d = S_OUT;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            // a second operator, or an unknown byte
            err_d = 1'b1;
          end
        end
      end

      S_OUT: begin
        // Bytes arriving here are dropped; only the handshake moves us on.
        if (op_ready) begin
          state_d = S_A;
          a_d     = '0;
          b_d     = '0;
          cnt_d   = '0;
          sub_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_A;
        a_d     = '0;
        b_d     = '0;
        cnt_d   = '0;
        sub_d   = 1'b0;
      end
    endcase

    // Any parse error abandons the expression completely.
    if (err_d) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      cnt_d   = '0;
      sub_d   = 1'b0;
    end
  end

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      err_q   <= err_d;
    end
  end

  // Outputs are driven straight from registers; inversion only while offering.
  always_comb begin
    op_valid = (state_q == S_OUT);
    op_a     = a_q;
    op_b     = (op_valid && sub_q) ? ~b_q : b_q;
`ifdef SUBTRACT_EN
    op_cin   = op_valid && sub_q;
`else
    op_cin   = 1'b0;
`endif
    err      = err_q;
  end

endmodule

// File: tb/tb_hex_operand_parser.sv
// Scoreboard bench for hex_operand_parser: stimulus pushes expected events
// (operand handshakes or error pulses), a negedge monitor pops and compares.
module tb_hex_operand_parser;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_cin;
  logic        op_valid;
  logic        op_ready;
  logic        err;

  hex_operand_parser #(.DATA_W(32), .MAX_DIGITS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_cin   (op_cin),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   hold_cnt;
  int   last_hold;

  task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic cin);
    exp_t e;
    e.is_err = 1'b0; e.a = a; e.b = b; e.cin = cin;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.a = '0; e.b = '0; e.cin = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: every error pulse and every accepted operand set pops one entry.
  always @(negedge clk) begin
    if (!rst) begin
      hold_cnt = op_valid ? hold_cnt + 1 : 0;
      if (err) begin
        checks++;
        if (exp_q.size() == 0 || !exp_q[0].is_err) begin
          errors++;
          $display("FAIL err_pulse: got err=1, expected no error here");
        end else begin
          void'(exp_q.pop_front());
          $display("err pulse observed as expected");
        end
      end
      if (op_valid && op_ready) begin
        exp_t e;
        checks++;
        last_hold = hold_cnt;
        if (exp_q.size() == 0 || exp_q[0].is_err) begin
          errors++;
          $display("FAIL op_handshake: got a=%h b=%h cin=%b, expected no operands", op_a, op_b, op_cin);
        end else begin
          e = exp_q.pop_front();
          if (op_a !== e.a || op_b !== e.b || op_cin !== e.cin) begin
            errors++;
            $display("FAIL op_values: got a=%h b=%h cin=%b, expected a=%h b=%h cin=%b",
                     op_a, op_b, op_cin, e.a, e.b, e.cin);
          end else begin
            $display("op a=%h b=%h cin=%b hold=%0d ok", op_a, op_b, op_cin, hold_cnt);
          end
        end
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    hold_cnt  = 0;
    last_hold = 0;
    rst       = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    op_ready  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_op_a", op_a, 32'h0);
    chk("reset_op_b", op_b, 32'h0);
    chk("reset_op_cin", 32'(op_cin), 32'h0);
    chk("reset_op_valid", 32'(op_valid), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    rst = 1'b0;

    // Reset in the middle of "12+3" discards the partial expression.
    send_str("12+3");
    chk("partial_op_a", op_a, 32'h12);
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    chk("midrst_op_valid", 32'(op_valid), 32'h0);
    chk("midrst_op_a", op_a, 32'h0);
    chk("midrst_op_b", op_b, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_op(32'h7, 32'h1, 1'b0);
    send_str("7+1=");
    wait_drain("after_reset");

    // Basic expression, ready held high: one-cycle valid.
    push_op(32'h12, 32'h34, 1'b0);
    send_str("12+34=");
    wait_drain("basic");
    chk("basic_hold_len", 32'(last_hold), 32'd1);

    // Mixed case, CR terminator, back-pressure, byte dropped while holding.
    op_ready = 1'b0;
    push_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
    send_str("ffffFFFF+1");
    send_byte(8'h0D);
    for (int i = 0; i < 20 && !op_valid; i++) @(negedge clk);
    chk("hold_valid_up", 32'(op_valid), 32'h1);
    send_byte(8'h39);
    repeat (4) @(posedge clk);
    #1;
    op_ready = 1'b1;
    wait_drain("backpressure");
    chk("hold_len_ge5", 32'(last_hold >= 5), 32'h1);

    // Nine digits overflow; parser recovers for the next expression.
    push_err();
    send_str("123456789");
    push_op(32'hA, 32'hB, 1'b0);
    send_str("A+B=");
    wait_drain("overflow");

    // Exactly MAX_DIGITS with leading zeros is accepted.
    push_op(32'h00000001, 32'hFFFFFFFF, 1'b0);
    send_str("00000001+FFFFFFFF=");
    wait_drain("max_digits");

    // Spaces ignored, lowercase accepted.
    push_op(32'h12, 32'hCD, 1'b0);
    send_str("1 2 + cD =");
    wait_drain("spaces");

    // "+5=": leading '+' errors, then '=' arrives in S_A and errors again.
    push_err();
    push_err();
    send_str("+5=");
    // "5+=": terminator with an empty B.
    push_err();
    send_str("5+=");
    // "5x": unrecognised byte.
    push_err();
    send_str("5x");
    wait_drain("bad_syntax");

`ifdef SUBTRACT_EN
    push_op(32'h10, 32'hFFFFFFFC, 1'b1);
    send_str("10-3=");
    wait_drain("subtract");
`else
    // '-' is unknown, then '=' in S_A is a second error.
    push_err();
    push_err();
    send_str("10-3=");
    wait_drain("no_subtract");
`endif

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
